// File: rtl/aesl_axis_block_detector_pkg.sv
// Shared types and constants for the AXI-Stream block detector.
package aesl_axis_block_detector_pkg;

    // Per-port stall FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_BLOCKED = 2'd2
    } port_state_e;

    // Width and saturation value of the block event counter
    localparam int unsigned BLOCK_EVT_W = 16;
    localparam logic [BLOCK_EVT_W-1:0] BLOCK_EVT_MAX = '1;

    // Index width for a port number, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aesl_axis_block_detector_port_stall.sv
// Per-port stall tracker: IDLE/WAIT/BLOCKED FSM with a consecutive-stall counter.
module aesl_axis_port_stall
    import aesl_axis_block_detector_pkg::*;
#(
    parameter int unsigned STALL_THRESH = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_req,
    input  logic i_avail,
    output logic o_blocked,
    output logic o_enter_c,
    output logic o_blocked_nxt_c
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

    port_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_blocked;

    logic             w_stall;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;

    assign w_stall   = i_req & ~i_avail;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Counter is 0 in IDLE, so the same compare covers THRESH=1 from IDLE
    assign w_hit     = (w_cnt_inc == THRESH);

    // Entry into BLOCKED at the coming edge, and blocked state after it
    always_comb begin
        o_enter_c       = 1'b0;
        o_blocked_nxt_c = 1'b0;
        if (!reset && w_stall) begin
            o_enter_c       = (r_state != ST_BLOCKED) && w_hit;
            o_blocked_nxt_c = (r_state == ST_BLOCKED) || o_enter_c;
        end
    end

    // Stall FSM, counter and registered blocked flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_blocked <= 1'b0;
        end else begin
            r_blocked <= o_blocked_nxt_c;
            case (r_state)
                ST_IDLE: begin
                    if (w_stall) begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= w_hit ? ST_BLOCKED : ST_WAIT;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_stall) begin
                        r_cnt <= w_cnt_inc;
                        if (w_hit) begin
                            r_state <= ST_BLOCKED;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_BLOCKED: begin
                    // Counter holds while blocked
                    if (!w_stall) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_blocked = r_blocked;

endmodule

// File: rtl/aesl_axis_block_detector.sv
// Observes NUM_PORTS AXI-Stream handshakes and flags ports stalled too long.
module aesl_axis_block_detector
    import aesl_axis_block_detector_pkg::*;
#(
    parameter  int unsigned NUM_PORTS    = 2,
    parameter  int unsigned STALL_THRESH = 16,
    parameter  int unsigned CNT_W        = 8,
    localparam int unsigned IDX_W        = idx_width(NUM_PORTS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   proc_req,
    input  logic [NUM_PORTS-1:0]   strm_avail,
    output logic [NUM_PORTS-1:0]   axis_block_sigs,
    output logic                   any_block,
    output logic [BLOCK_EVT_W-1:0] block_events,
    output logic [IDX_W-1:0]       first_block_idx,
    output logic                   first_block_vld
);

    localparam int unsigned ENTER_W = $clog2(NUM_PORTS + 1);
    localparam int unsigned SUM_W   = BLOCK_EVT_W + 1;

    logic [NUM_PORTS-1:0]   w_blocked;
    logic [NUM_PORTS-1:0]   w_enter;
    logic [NUM_PORTS-1:0]   w_blocked_nxt;
    logic [ENTER_W-1:0]     w_enter_cnt;
    logic [SUM_W-1:0]       w_events_sum;
    logic [IDX_W-1:0]       w_first_idx;

    logic                   r_any_block;
    logic [BLOCK_EVT_W-1:0] r_block_events;
    logic [IDX_W-1:0]       r_first_idx;
    logic                   r_first_vld;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        aesl_axis_port_stall #(
            .STALL_THRESH (STALL_THRESH),
            .CNT_W        (CNT_W)
        ) u_port (
            .clock           (clock),
            .reset           (reset),
            .i_req           (proc_req[g]),
            .i_avail         (strm_avail[g]),
            .o_blocked       (w_blocked[g]),
            .o_enter_c       (w_enter[g]),
            .o_blocked_nxt_c (w_blocked_nxt[g])
        );
    end

    // Count simultaneous entries and pick the lowest entering index
    always_comb begin
        w_enter_cnt = '0;
        w_first_idx = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            w_enter_cnt = w_enter_cnt + ENTER_W'(w_enter[i]);
        end
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (w_enter[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
        w_events_sum = {1'b0, r_block_events} + SUM_W'(w_enter_cnt);
    end

    // Aggregate flags, saturating event counter and sticky first-block capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_any_block    <= 1'b0;
            r_block_events <= '0;
            r_first_idx    <= '0;
            r_first_vld    <= 1'b0;
        end else begin
            r_any_block    <= |w_blocked_nxt;
            r_block_events <= w_events_sum[SUM_W-1] ? BLOCK_EVT_MAX
                                                    : w_events_sum[BLOCK_EVT_W-1:0];
            if (!r_first_vld && (|w_enter)) begin
                r_first_vld <= 1'b1;
                r_first_idx <= w_first_idx;
            end
        end
    end

    assign axis_block_sigs = w_blocked;
    assign any_block       = r_any_block;
    assign block_events    = r_block_events;
    assign first_block_idx = r_first_idx;
    assign first_block_vld = r_first_vld;

endmodule
